// File: rtl/pll_reset_pkg.sv
// Shared types and width helpers for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        StPllRst   = 2'd0,
        StWaitLock = 2'd1,
        StMemRel   = 2'd2,
        StRun      = 2'd3
    } seq_state_e;

    localparam int unsigned RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

    // Width of a counter that must hold the value n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock, then releases memory and system resets in order.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 32,
    parameter int unsigned LOCK_FILTER    = 256,
    parameter int unsigned STAGE_DELAY    = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               sw_reset_req,
    output logic               pll_rst,
    output logic               mem_reset_n,
    output logic               sys_reset_n,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int unsigned DLY_W  = max_u(cnt_w(PLL_RST_CYCLES), cnt_w(STAGE_DELAY));
    localparam int unsigned LOCK_W = cnt_w(LOCK_FILTER);
    localparam int unsigned TO_W   = cnt_w(LOCK_TIMEOUT);

    localparam logic [DLY_W-1:0]  RST_END   = DLY_W'(PLL_RST_CYCLES);
    localparam logic [DLY_W-1:0]  STAGE_END = DLY_W'(STAGE_DELAY);
    localparam logic [LOCK_W-1:0] LOCK_END  = LOCK_W'(LOCK_FILTER);
    localparam logic [TO_W-1:0]   TO_END    = TO_W'(LOCK_TIMEOUT);

    logic locked_s;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    seq_state_e         state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d, dly_inc;
    logic [LOCK_W-1:0]  lock_q, lock_d, lock_inc;
    logic [TO_W-1:0]    to_q, to_d, to_inc;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, mem_reset_n_q, sys_reset_n_q;

    // Counters are cleared by default so that every state change starts them from 0.
    always_comb begin
        state_d  = state_q;
        dly_d    = '0;
        lock_d   = '0;
        to_d     = '0;
        retry_d  = retry_q;
        dly_inc  = (dly_q == '1) ? dly_q : dly_q + DLY_W'(1);
        lock_inc = (lock_q == LOCK_END) ? lock_q : lock_q + LOCK_W'(1);
        to_inc   = (to_q == TO_END) ? to_q : to_q + TO_W'(1);

        unique case (state_q)
            StPllRst: begin
                if (dly_inc == RST_END) begin
                    state_d = StWaitLock;
                end else begin
                    dly_d = dly_inc;
                end
            end
            StWaitLock: begin
                // Lock takes precedence over a coincident timeout.
                if (locked_s && (lock_inc == LOCK_END)) begin
                    state_d = StMemRel;
                end else if (to_inc == TO_END) begin
                    state_d = StPllRst;
                    retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);
                end else begin
                    lock_d = locked_s ? lock_inc : '0;
                    to_d   = to_inc;
                end
            end
            StMemRel: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (dly_inc == STAGE_END) begin
                    state_d = StRun;
                end else begin
                    dly_d = dly_inc;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end
            end
            default: state_d = StPllRst;
        endcase

        if (sw_reset_req) begin
            state_d = StPllRst;
            dly_d   = '0;
            lock_d  = '0;
            to_d    = '0;
            retry_d = retry_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StPllRst;
            dly_q         <= '0;
            lock_q        <= '0;
            to_q          <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            mem_reset_n_q <= 1'b0;
            sys_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dly_q         <= dly_d;
            lock_q        <= lock_d;
            to_q          <= to_d;
            retry_q       <= retry_d;
            pll_rst_q     <= (state_d == StPllRst);
            mem_reset_n_q <= (state_d == StMemRel) || (state_d == StRun);
            sys_reset_n_q <= (state_d == StRun);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign mem_reset_n = mem_reset_n_q;
    assign sys_reset_n = sys_reset_n_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer against a cycle-level behavioural model.
module tb_pll_reset_sequencer;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned PRC   = 4;
    localparam int unsigned LF    = 8;
    localparam int unsigned SD    = 4;
    localparam int unsigned LT    = 100;

    localparam int PH_PLL  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_MEM  = 2;
    localparam int PH_RUN  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       mem_reset_n;
    logic       sys_reset_n;
    logic [3:0] retry_count;

    int n_checks = 0;
    int n_bad    = 0;

    // Model: phase, edges spent in the phase, consecutive synchronized-high edges, retries.
    int m_ph;
    int m_since;
    int m_streak;
    int m_retries;
    bit m_sync [SYNC];

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .PLL_RST_CYCLES(PRC),
        .LOCK_FILTER   (LF),
        .STAGE_DELAY   (SD),
        .LOCK_TIMEOUT  (LT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .sw_reset_req(sw_reset_req),
        .pll_rst     (pll_rst),
        .mem_reset_n (mem_reset_n),
        .sys_reset_n (sys_reset_n),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph      = PH_PLL;
        m_since   = 0;
        m_streak  = 0;
        m_retries = 0;
        for (int i = 0; i < int'(SYNC); i++) m_sync[i] = 1'b0;
    endtask

    task automatic model_edge(input bit lk, input bit sw);
        bit ls;
        int nxt;
        ls = m_sync[SYNC-1];
        for (int i = int'(SYNC) - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = lk;
        m_since++;
        nxt = m_ph;
        if (m_ph == PH_WAIT) m_streak = ls ? m_streak + 1 : 0;
        if (sw) begin
            nxt = PH_PLL;
        end else if (m_ph == PH_PLL) begin
            if (m_since == int'(PRC)) nxt = PH_WAIT;
        end else if (m_ph == PH_WAIT) begin
            if (m_streak == int'(LF)) begin
                nxt = PH_MEM;
            end else if (m_since == int'(LT)) begin
                nxt = PH_PLL;
                if (m_retries < 15) m_retries++;
            end
        end else if (!ls) begin
            nxt = PH_WAIT;
        end else if (m_ph == PH_MEM && m_since == int'(SD)) begin
            nxt = PH_RUN;
        end
        if (sw || nxt != m_ph) begin
            m_ph     = nxt;
            m_since  = 0;
            m_streak = 0;
        end
    endtask

    task automatic compare_outputs();
        check_eq("pll_rst", pll_rst, m_ph == PH_PLL);
        check_eq("mem_reset_n", mem_reset_n, m_ph >= PH_MEM);
        check_eq("sys_reset_n", sys_reset_n, m_ph == PH_RUN);
        check_eq("retry_count", retry_count, m_retries);
        check_eq("reset_order", sys_reset_n & ~mem_reset_n, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(pll_locked, sw_reset_req);
        #1;
        compare_outputs();
    endtask

    task automatic run_until_phase(input string tag, input int ph, input int budget);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            step();
            n++;
        end
        if (m_ph != ph) check_eq(tag, m_ph, ph);
    endtask

    int n;
    int r1;
    int r2;
    int seg_len;
    int saved_retry;
    bit prev_pll;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        pll_locked   = 1'b1;
        sw_reset_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        compare_outputs();

        // Clean start.
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (!pll_rst) break;
        end
        check_eq("pll_rst_width", n, PRC);
        while (!mem_reset_n && n < 50) begin
            step();
            n++;
        end
        check_eq("mem_release_edge", n, PRC + SYNC + LF - SYNC);
        n = 0;
        while (!sys_reset_n && n < 20) begin
            step();
            n++;
        end
        check_eq("sys_release_gap", n, SD);

        // Software restart, then chattering lock.
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            pll_locked = (i % 5 != 4);
            step();
        end
        check_eq("chatter_mem_low", mem_reset_n, 0);
        pll_locked = 1'b1;
        n = 0;
        while (!mem_reset_n && n < 40) begin
            step();
            n++;
        end
        check_eq("chatter_mem_release", n, SYNC + LF);
        run_until_phase("chatter_to_run", PH_RUN, 20);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        n = 0;
        while (mem_reset_n && n < 20) begin
            step();
            n++;
        end
        check_eq("lock_loss_latency", n, SYNC + 1);
        check_eq("lock_loss_no_pll_rst", pll_rst, 0);
        pll_locked = 1'b1;
        run_until_phase("relock_to_run", PH_RUN, 40);

        // Software request coinciding with lock loss.
        saved_retry = m_retries;
        pll_locked  = 1'b0;
        step();
        step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        n = 1;
        while (n < 20) begin
            step();
            if (!pll_rst) break;
            n++;
        end
        check_eq("sw_pll_rst_width", n, PRC);
        check_eq("sw_retry_unchanged", retry_count, saved_retry);

        // No lock: periodic retries saturating at 15.
        r1 = -1;
        r2 = -1;
        prev_pll = pll_rst;
        for (int i = 0; i < 16 * int'(PRC + LT) + 40; i++) begin
            step();
            if (pll_rst && !prev_pll) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            prev_pll = pll_rst;
        end
        check_eq("retry_period", r2 - r1, PRC + LT);
        check_eq("retry_saturated", retry_count, 15);

        // Asynchronous reset while in MEM_REL.
        pll_locked = 1'b1;
        run_until_phase("reach_mem_rel", PH_MEM, 200);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_pll_rst", pll_rst, 1);
        check_eq("async_mem_reset_n", mem_reset_n, 0);
        check_eq("async_sys_reset_n", sys_reset_n, 0);
        check_eq("async_retry_count", retry_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        compare_outputs();
        run_until_phase("post_reset_run", PH_RUN, 40);

        // Random lock behaviour with occasional software requests.
        for (int seg = 0; seg < 120; seg++) begin
            seg_len    = $urandom_range(1, 25);
            pll_locked = (seg % 2 == 0);
            if (!pll_locked && $urandom_range(0, 9) == 0) seg_len = 130;
            for (int i = 0; i < seg_len; i++) begin
                sw_reset_req = ($urandom_range(0, 149) == 0);
                step();
            end
        end
        sw_reset_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
